// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns debug commands, load-use stalls, taken branches and
// decoded HALT into per-stage register enables/flushes, draining before freezing.
module pipeline_ctrl #(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic                 i_halt_req,
    input  logic                 i_load_use,
    input  logic                 i_branch_taken,
    input  logic                 i_halt_instr,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic [2:0]           o_state,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            adv;
    logic            halt_accept;

    assign adv         = (state == RUN) || (state == STEP) || (state == DRAIN);
    // A load-use stall holds the HALT in ID, so it cannot be accepted that cycle.
    assign halt_accept = ((state == RUN) || (state == STEP)) && i_halt_instr && !i_load_use;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            o_cycle_cnt <= '0;
        end else begin
            if (adv && !(&o_cycle_cnt))
                o_cycle_cnt <= o_cycle_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (i_start)     state <= RUN;
                    else if (i_step) state <= STEP;
                end
                RUN: begin
                    if (halt_accept) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else if (i_halt_req) begin
                        state <= IDLE;
                    end
                end
                STEP: begin
                    if (halt_accept) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= DONE;
                    else                         drain_cnt <= drain_cnt + 1'b1;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_en    = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;

        case (state)
            RUN, STEP: begin
                o_id_ex_en  = 1'b1;
                o_ex_mem_en = 1'b1;
                o_mem_wb_en = 1'b1;
                if (i_load_use) begin
                    o_id_ex_flush = 1'b1;
                end else if (i_halt_instr) begin
                    o_if_id_flush = 1'b1;
                end else begin
                    o_pc_en       = 1'b1;
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = i_branch_taken;
                end
            end
            DRAIN: begin
                o_id_ex_en    = 1'b1;
                o_ex_mem_en   = 1'b1;
                o_mem_wb_en   = 1'b1;
                o_id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state = state;
    assign o_done  = (state == DONE);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table walking RUN/stall/branch/STEP/HALT/DONE,
// plus hand sequences for step pulses, STEP-to-DRAIN and reset mid-drain.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start, i_step, i_halt_req, i_load_use, i_branch_taken, i_halt_instr;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [2:0]  state;
    logic        done;
    logic [31:0] cycle_cnt;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_done;
    logic [2:0]  s_state;
    logic [2:0]  s_cycle_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_WIDTH(32), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_step(i_step),
        .i_halt_req(i_halt_req), .i_load_use(i_load_use),
        .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_state(state), .o_done(done), .o_cycle_cnt(cycle_cnt)
    );

    // Narrow-counter copy on the same stimulus, used only to observe saturation.
    pipeline_ctrl #(.CNT_WIDTH(3), .DRAIN_CYCLES(3)) dut_sat (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_step(i_step),
        .i_halt_req(i_halt_req), .i_load_use(i_load_use),
        .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr),
        .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_id_ex_en(s_id_ex_en),
        .o_ex_mem_en(s_ex_mem_en), .o_mem_wb_en(s_mem_wb_en),
        .o_if_id_flush(s_if_id_flush), .o_id_ex_flush(s_id_ex_flush),
        .o_state(s_state), .o_done(s_done), .o_cycle_cnt(s_cycle_cnt)
    );

    typedef struct packed {
        logic [5:0]  in;   // {start, step, halt_req, load_use, branch, halt_instr}
        logic [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0]  fl;   // {if_id, id_ex}
        logic [2:0]  st;
        logic        dn;
        logic [31:0] cnt;
    } vec_t;

    localparam logic [5:0] N = 6'b000000, ST = 6'b100000, SP = 6'b010000, HR = 6'b001000,
                           LU = 6'b000100, BR = 6'b000010, HI = 6'b000001;

    vec_t vecs[22];

    function automatic vec_t mk(logic [5:0] in, logic [4:0] en, logic [1:0] fl,
                                logic [2:0] st, logic dn, logic [31:0] cnt);
        vec_t v;
        v.in = in; v.en = en; v.fl = fl; v.st = st; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(logic [5:0] in);
        {i_start, i_step, i_halt_req, i_load_use, i_branch_taken, i_halt_instr} = in;
    endtask

    function automatic logic [42:0] observed();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, state, done, cycle_cnt};
    endfunction

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        i_rst = 1'b1;
        drive(N);
        @(posedge clk);
        @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    // Drive inputs, let outputs settle, check, then advance one edge.
    task automatic step_vec(string name, vec_t v);
        drive(v.in);
        #1;
        check(name, 64'(observed()), 64'({v.en, v.fl, v.st, v.dn, v.cnt}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int      en_cycles;
        logic [2:0] exp_st[12];

        vecs[0]  = mk(ST,         5'b00000, 2'b00, 3'd0, 1'b0, 0);
        vecs[1]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 0);
        vecs[2]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 1);
        vecs[3]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 2);
        vecs[4]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 3);
        vecs[5]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 4);
        vecs[6]  = mk(LU | BR,    5'b00111, 2'b01, 3'd1, 1'b0, 5);
        vecs[7]  = mk(N,          5'b11111, 2'b00, 3'd1, 1'b0, 6);
        vecs[8]  = mk(BR,         5'b11111, 2'b10, 3'd1, 1'b0, 7);
        vecs[9]  = mk(LU | HI,    5'b00111, 2'b01, 3'd1, 1'b0, 8);
        vecs[10] = mk(HR,         5'b11111, 2'b00, 3'd1, 1'b0, 9);
        vecs[11] = mk(N,          5'b00000, 2'b00, 3'd0, 1'b0, 10);
        vecs[12] = mk(SP,         5'b00000, 2'b00, 3'd0, 1'b0, 10);
        vecs[13] = mk(HR | SP,    5'b11111, 2'b00, 3'd2, 1'b0, 10);
        vecs[14] = mk(N,          5'b00000, 2'b00, 3'd0, 1'b0, 11);
        vecs[15] = mk(ST | SP,    5'b00000, 2'b00, 3'd0, 1'b0, 11);
        vecs[16] = mk(HI,         5'b00111, 2'b10, 3'd1, 1'b0, 11);
        vecs[17] = mk(HR|LU|BR,   5'b00111, 2'b01, 3'd3, 1'b0, 12);
        vecs[18] = mk(N,          5'b00111, 2'b01, 3'd3, 1'b0, 13);
        vecs[19] = mk(N,          5'b00111, 2'b01, 3'd3, 1'b0, 14);
        vecs[20] = mk(ST,         5'b00000, 2'b00, 3'd4, 1'b1, 15);
        vecs[21] = mk(SP | HR,    5'b00000, 2'b00, 3'd4, 1'b1, 15);

        // Reset state
        do_reset();
        check("reset_outputs", 64'(observed()), 64'(0));

        foreach (vecs[i]) step_vec($sformatf("vec%0d", i), vecs[i]);
        check("sat_cnt", 64'(s_cycle_cnt), 64'(7));
        check("sat_done", 64'(s_done), 64'(1));

        // Two step pulses four cycles apart: one advance cycle each.
        do_reset();
        exp_st = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        en_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            drive((c == 0 || c == 4) ? SP : N);
            #1;
            check($sformatf("step_state_c%0d", c), 64'(state), 64'(exp_st[c]));
            if (pc_en | if_id_en | id_ex_en | ex_mem_en | mem_wb_en) en_cycles++;
            @(posedge clk);
            #1;
        end
        check("step_en_cycles", 64'(en_cycles), 64'(2));
        check("step_cnt", 64'(cycle_cnt), 64'(2));

        // HALT decoded during a STEP enters DRAIN and finishes in DONE.
        step_vec("sd_idle", mk(SP, 5'b00000, 2'b00, 3'd0, 1'b0, 2));
        step_vec("sd_accept", mk(HI, 5'b00111, 2'b10, 3'd2, 1'b0, 2));
        step_vec("sd_drain0", mk(N, 5'b00111, 2'b01, 3'd3, 1'b0, 3));
        step_vec("sd_drain1", mk(N, 5'b00111, 2'b01, 3'd3, 1'b0, 4));
        step_vec("sd_drain2", mk(N, 5'b00111, 2'b01, 3'd3, 1'b0, 5));
        step_vec("sd_done", mk(N, 5'b00000, 2'b00, 3'd4, 1'b1, 6));

        // Reset asserted in the second DRAIN cycle wins over everything.
        do_reset();
        step_vec("rd_start", mk(ST, 5'b00000, 2'b00, 3'd0, 1'b0, 0));
        step_vec("rd_run", mk(N, 5'b11111, 2'b00, 3'd1, 1'b0, 0));
        step_vec("rd_accept", mk(HI, 5'b00111, 2'b10, 3'd1, 1'b0, 1));
        step_vec("rd_drain0", mk(N, 5'b00111, 2'b01, 3'd3, 1'b0, 2));
        drive(ST);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        drive(N);
        #1;
        check("rd_after_reset", 64'(observed()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
